// File: rtl/sdram_request_buffer_pkg.sv
// Shared types and default widths for the music-box SDRAM request path.
// Request entries are packed so the queue stores one word per command.
package music_box_pkg;

  localparam int SRB_DEPTH   = 4;
  localparam int SRB_ADDR_W  = 25;
  localparam int SRB_DATA_W  = 16;
  localparam int SRB_TIMEOUT = 1023;

  typedef struct packed {
    logic [SRB_ADDR_W-1:0] addr;
    logic [SRB_DATA_W-1:0] wdata;
    logic                  is_write;
  } sdram_req_t;

  typedef enum logic [1:0] {
    SRB_IDLE      = 2'd0,
    SRB_ISSUE     = 2'd1,
    SRB_WAIT_READ = 2'd2
  } srb_state_t;

endpackage

// File: rtl/sdram_request_buffer_if.sv
// Request-side and controller-side buses of the SDRAM request buffer.
// master drives the command, slave answers it.
interface srb_req_if #(
  parameter int ADDR_W = 25,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] req_inputAddress;
  logic [DATA_W-1:0] req_writeData;
  logic              req_isWriting;
  logic              req_inputValid;
  logic              req_ready;
  logic [DATA_W-1:0] rsp_readData;
  logic              rsp_outputValid;

  modport master (
    output req_inputAddress, req_writeData, req_isWriting, req_inputValid,
    input  req_ready, rsp_readData, rsp_outputValid
  );
  modport slave (
    input  req_inputAddress, req_writeData, req_isWriting, req_inputValid,
    output req_ready, rsp_readData, rsp_outputValid
  );
endinterface

interface srb_sdram_if #(
  parameter int ADDR_W = 25,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] sdram_inputAddress;
  logic [DATA_W-1:0] sdram_writeData;
  logic              sdram_isWriting;
  logic              sdram_inputValid;
  logic [DATA_W-1:0] sdram_readData;
  logic              sdram_outputValid;
  logic              sdram_recievedCommand;
  logic              sdram_isBusy;

  modport master (
    output sdram_inputAddress, sdram_writeData, sdram_isWriting, sdram_inputValid,
    input  sdram_readData, sdram_outputValid, sdram_recievedCommand, sdram_isBusy
  );
  modport slave (
    input  sdram_inputAddress, sdram_writeData, sdram_isWriting, sdram_inputValid,
    output sdram_readData, sdram_outputValid, sdram_recievedCommand, sdram_isBusy
  );
endinterface

// File: rtl/sdram_request_buffer_fifo.sv
// DEPTH-entry synchronous FIFO of sdram_req_t; head is readable combinationally.
// Push while full and pop while empty are ignored; flush empties it next cycle.
module sdram_req_fifo
  import music_box_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_flush,
  input  sdram_req_t             i_dat,
  output sdram_req_t             o_dat,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  sdram_req_t          r_mem [DEPTH];
  logic [AW-1:0]       r_wptr;
  logic [AW-1:0]       r_rptr;
  logic [CW-1:0]       r_count;
  logic                w_push;
  logic                w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dat   = r_mem[r_rptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_dat;
  end

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/sdram_request_buffer.sv
// Queues SDRAM requests and issues them one at a time, holding each until accepted.
// Read data returns as a one-cycle pulse; overflow and controller timeouts are sticky.
module sdram_request_buffer
  import music_box_pkg::*;
#(
  parameter int DEPTH          = SRB_DEPTH,
  parameter int ADDR_W         = SRB_ADDR_W,
  parameter int DATA_W         = SRB_DATA_W,
  parameter int TIMEOUT_CYCLES = SRB_TIMEOUT
) (
  input  logic                   clock_50Mhz,
  input  logic                   reset,
  input  logic                   flush,
  srb_req_if.slave               req,
  srb_sdram_if.master            sdram,
  output logic [$clog2(DEPTH):0] queueCount,
  output logic                   overflowError,
  output logic                   timeoutError
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [1:0] ST_IDLE      = SRB_IDLE;
  localparam logic [1:0] ST_ISSUE     = SRB_ISSUE;
  localparam logic [1:0] ST_WAIT_READ = SRB_WAIT_READ;

  logic [1:0]        r_state;
  sdram_req_t        r_cmd;
  logic              r_ivld;
  logic              r_rsp_vld;
  logic [DATA_W-1:0] r_rsp_dat;
  logic              r_ovf;
  logic              r_tmo;
  logic              r_drop;
  logic [TW-1:0]     r_timer;

  sdram_req_t        w_in;
  sdram_req_t        w_head;
  sdram_req_t        w_next;
  logic              w_full;
  logic              w_empty;
  logic              w_push_req;
  logic              w_issue_ok;
  logic              w_issue;
  logic              w_bypass;
  logic              w_pop;
  logic              w_timer_hit;
  logic              w_deliver;

  assign w_in        = '{addr: req.req_inputAddress, wdata: req.req_writeData,
                         is_write: req.req_isWriting};
  assign w_push_req  = req.req_inputValid && !w_full && !flush;
  assign w_issue_ok  = (r_state == ST_IDLE) && !sdram.sdram_isBusy && !flush;
  // An empty queue forwards the incoming request straight to the controller.
  assign w_bypass    = w_issue_ok && w_empty && w_push_req;
  assign w_issue     = w_issue_ok && (!w_empty || w_push_req);
  assign w_pop       = w_issue && !w_empty;
  assign w_next      = w_empty ? w_in : w_head;
  assign w_timer_hit = (r_timer == TW'(TIMEOUT_CYCLES - 1));
  assign w_deliver   = !(r_drop || flush);

  sdram_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clock_50Mhz),
    .rst     (reset),
    .i_push  (w_push_req && !w_bypass),
    .i_pop   (w_pop),
    .i_flush (flush),
    .i_dat   (w_in),
    .o_dat   (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (queueCount)
  );

  always_ff @(posedge clock_50Mhz) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cmd     <= '0;
      r_ivld    <= 1'b0;
      r_rsp_vld <= 1'b0;
      r_rsp_dat <= '0;
      r_ovf     <= 1'b0;
      r_tmo     <= 1'b0;
      r_drop    <= 1'b0;
      r_timer   <= '0;
    end else begin
      r_rsp_vld <= 1'b0;
      if (req.req_inputValid && w_full) r_ovf <= 1'b1;
      // A flush while a read is in flight suppresses its response.
      if (flush && r_state != ST_IDLE) r_drop <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_issue) begin
            r_cmd   <= w_next;
            r_ivld  <= 1'b1;
            r_timer <= '0;
            r_drop  <= 1'b0;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (sdram.sdram_recievedCommand) begin
            r_ivld <= 1'b0;
            if (r_cmd.is_write) begin
              r_state <= ST_IDLE;
            end else if (sdram.sdram_outputValid) begin
              if (w_deliver) begin
                r_rsp_dat <= sdram.sdram_readData;
                r_rsp_vld <= 1'b1;
              end
              r_state <= ST_IDLE;
            end else begin
              r_timer <= '0;
              r_state <= ST_WAIT_READ;
            end
          end else if (w_timer_hit) begin
            r_ivld  <= 1'b0;
            r_tmo   <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_WAIT_READ: begin
          if (sdram.sdram_outputValid) begin
            if (w_deliver) begin
              r_rsp_dat <= sdram.sdram_readData;
              r_rsp_vld <= 1'b1;
            end
            r_state <= ST_IDLE;
          end else if (w_timer_hit) begin
            r_tmo   <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req.req_ready          = !w_full;
  assign req.rsp_readData       = r_rsp_dat;
  assign req.rsp_outputValid    = r_rsp_vld;
  assign sdram.sdram_inputAddress = r_cmd.addr;
  assign sdram.sdram_writeData    = r_cmd.wdata;
  assign sdram.sdram_isWriting    = r_cmd.is_write;
  assign sdram.sdram_inputValid   = r_ivld;
  assign overflowError            = r_ovf;
  assign timeoutError             = r_tmo;
endmodule

// File: tb/tb_sdram_request_buffer.sv
// Bench for sdram_request_buffer: directed scenarios plus random traffic,
// all checked every cycle against a queue-based transaction model.
module tb_sdram_request_buffer;
  import music_box_pkg::*;

  localparam int DEPTH = 4;
  localparam int TMO   = 1023;

  logic       clk = 1'b0;
  logic       reset;
  logic       flush;
  logic [2:0] queueCount;
  logic       overflowError;
  logic       timeoutError;

  srb_req_if   rq ();
  srb_sdram_if sd ();

  sdram_request_buffer #(.DEPTH(DEPTH), .ADDR_W(25), .DATA_W(16), .TIMEOUT_CYCLES(TMO)) dut (
    .clock_50Mhz   (clk),
    .reset         (reset),
    .flush         (flush),
    .req           (rq.slave),
    .sdram         (sd.master),
    .queueCount    (queueCount),
    .overflowError (overflowError),
    .timeoutError  (timeoutError)
  );

  always #10 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // ---------------- transaction model ----------------
  bit          m_ok = 0;
  int unsigned m_edge;
  sdram_req_t  q[$];
  sdram_req_t  m_cmd;
  bit          m_ivld, m_rsp_vld, m_ovf, m_tmo, m_drop;
  logic [15:0] m_rsp_dat;
  int          m_phase;   // 0 nothing outstanding, 1 waiting for accept, 2 waiting for read data
  int unsigned m_since;

  always @(posedge clk) begin
    sdram_req_t inreq;
    bit full, push_ok, take_head, bypass;
    int pre;
    m_edge++;
    if (reset) begin
      q.delete();
      m_cmd = '0; m_ivld = 0; m_rsp_vld = 0; m_ovf = 0; m_tmo = 0; m_drop = 0;
      m_rsp_dat = '0; m_phase = 0; m_ok = 1;
    end else if (m_ok) begin
      inreq     = '{addr: rq.req_inputAddress, wdata: rq.req_writeData, is_write: rq.req_isWriting};
      full      = (q.size() == DEPTH);
      push_ok   = rq.req_inputValid && !full && !flush;
      take_head = 0;
      bypass    = 0;
      pre       = m_phase;
      m_rsp_vld = 0;
      case (m_phase)
        0: if (!sd.sdram_isBusy && !flush && (q.size() > 0 || push_ok)) begin
             if (q.size() > 0) begin m_cmd = q[0]; take_head = 1; end
             else begin m_cmd = inreq; bypass = 1; end
             m_ivld = 1; m_phase = 1; m_since = m_edge + 1; m_drop = 0;
           end
        1: if (sd.sdram_recievedCommand) begin
             m_ivld = 0;
             if (m_cmd.is_write) m_phase = 0;
             else if (sd.sdram_outputValid) begin
               if (!(m_drop || flush)) begin m_rsp_vld = 1; m_rsp_dat = sd.sdram_readData; end
               m_phase = 0;
             end else begin
               m_phase = 2; m_since = m_edge + 1;
             end
           end else if (m_edge - m_since == TMO - 1) begin
             m_ivld = 0; m_tmo = 1; m_phase = 0;
           end
        default: if (sd.sdram_outputValid) begin
             if (!(m_drop || flush)) begin m_rsp_vld = 1; m_rsp_dat = sd.sdram_readData; end
             m_phase = 0;
           end else if (m_edge - m_since == TMO - 1) begin
             m_tmo = 1; m_phase = 0;
           end
      endcase
      if (flush && pre != 0) m_drop = 1;
      if (rq.req_inputValid && full) m_ovf = 1;
      if (flush) q.delete();
      else begin
        if (take_head) void'(q.pop_front());
        if (push_ok && !bypass) q.push_back(inreq);
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok && !reset) begin
      chk("sdram_inputValid",   sd.sdram_inputValid, m_ivld);
      chk("sdram_inputAddress", sd.sdram_inputAddress, m_cmd.addr);
      chk("sdram_writeData",    sd.sdram_writeData, m_cmd.wdata);
      chk("sdram_isWriting",    sd.sdram_isWriting, m_cmd.is_write);
      chk("rsp_outputValid",    rq.rsp_outputValid, m_rsp_vld);
      chk("rsp_readData",       rq.rsp_readData, m_rsp_dat);
      chk("overflowError",      overflowError, m_ovf);
      chk("timeoutError",       timeoutError, m_tmo);
      chk("queueCount",         queueCount, q.size());
      chk("req_ready",          rq.req_ready, q.size() != DEPTH);
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic push(input logic [24:0] a, input logic [15:0] d, input logic w);
    rq.req_inputValid = 1; rq.req_inputAddress = a; rq.req_writeData = d; rq.req_isWriting = w;
  endtask

  // Accepts whatever is presented, for up to 'budget' cycles, returning the accepted addresses.
  task automatic accept_n(input int n, input int budget, output logic [24:0] got_a[4], output int got);
    got = 0;
    for (int k = 0; k < budget && got < n; k++) begin
      sd.sdram_recievedCommand = sd.sdram_inputValid;
      if (sd.sdram_inputValid) begin got_a[got] = sd.sdram_inputAddress; got++; end
      cyc();
    end
    sd.sdram_recievedCommand = 0;
  endtask

  initial begin
    logic [24:0] acc[4];
    int got, waited;
    reset = 1; flush = 0;
    rq.req_inputValid = 0; rq.req_inputAddress = '0; rq.req_writeData = '0; rq.req_isWriting = 0;
    sd.sdram_readData = '0; sd.sdram_outputValid = 0; sd.sdram_recievedCommand = 0; sd.sdram_isBusy = 0;
    cyc(); cyc();
    chk("reset inputValid", sd.sdram_inputValid, 0);
    chk("reset req_ready", rq.req_ready, 1);
    chk("reset queueCount", queueCount, 0);
    chk("reset rsp_outputValid", rq.rsp_outputValid, 0);
    chk("reset errors", {overflowError, timeoutError}, 0);
    reset = 0;
    cyc();

    // 1: write, accepted in its second valid cycle
    push(25'h0000123, 16'hBEEF, 1);
    cyc();
    rq.req_inputValid = 0;
    chk("t1 valid c1", sd.sdram_inputValid, 1);
    chk("t1 addr c1", sd.sdram_inputAddress, 25'h0000123);
    chk("t1 data c1", sd.sdram_writeData, 16'hBEEF);
    cyc();
    chk("t1 valid c2", sd.sdram_inputValid, 1);
    chk("t1 addr c2", sd.sdram_inputAddress, 25'h0000123);
    sd.sdram_recievedCommand = 1;
    cyc();
    sd.sdram_recievedCommand = 0;
    chk("t1 valid c3", sd.sdram_inputValid, 0);
    chk("t1 no rsp", rq.rsp_outputValid, 0);
    cyc();

    // 2: read, data five cycles after accept
    push(25'h0000010, 16'h0, 0);
    cyc();
    rq.req_inputValid = 0;
    chk("t2 read issued", {sd.sdram_inputValid, sd.sdram_isWriting}, 2'b10);
    sd.sdram_recievedCommand = 1;
    cyc();
    sd.sdram_recievedCommand = 0;
    repeat (4) cyc();
    sd.sdram_outputValid = 1; sd.sdram_readData = 16'h00A5;
    cyc();
    sd.sdram_outputValid = 0;
    chk("t2 rsp pulse", rq.rsp_outputValid, 1);
    chk("t2 rsp data", rq.rsp_readData, 16'h00A5);
    cyc();
    chk("t2 rsp one cycle", rq.rsp_outputValid, 0);

    // 3: overflow while the controller is busy, then ordered drain
    sd.sdram_isBusy = 1;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) chk("t3 ready low when full", rq.req_ready, 0);
      push(25'h200 + 25'(i), 16'(i), 1);
      cyc();
    end
    rq.req_inputValid = 0;
    chk("t3 count", queueCount, 4);
    chk("t3 overflow", overflowError, 1);
    sd.sdram_isBusy = 0;
    accept_n(4, 60, acc, got);
    chk("t3 issued", got, 4);
    for (int i = 0; i < 4; i++) chk("t3 order", acc[i], 25'h200 + 25'(i));
    cyc();
    chk("t3 drained", queueCount, 0);

    // 4: read accepted but no data ever returns
    push(25'h300, 16'h0, 0);
    cyc();
    rq.req_inputValid = 0;
    sd.sdram_recievedCommand = 1;
    cyc();
    sd.sdram_recievedCommand = 0;
    waited = 1;
    push(25'h301, 16'h1234, 1);
    cyc();
    rq.req_inputValid = 0;
    waited = 2;
    while (!timeoutError && waited < 1100) begin cyc(); waited++; end
    chk("t4 timeout flag", timeoutError, 1);
    chk("t4 timeout cycles", waited, 1024);
    chk("t4 no rsp", rq.rsp_outputValid, 0);
    accept_n(1, 10, acc, got);
    chk("t4 next issued", got, 1);
    chk("t4 next addr", acc[0], 25'h301);
    cyc();

    // 5: flush with a read in flight and three queued
    push(25'h400, 16'h0, 0);
    cyc();
    rq.req_inputValid = 0;
    sd.sdram_recievedCommand = 1;
    cyc();
    sd.sdram_recievedCommand = 0;
    for (int i = 1; i < 4; i++) begin push(25'h400 + 25'(i), 16'(i), 1); cyc(); end
    rq.req_inputValid = 0;
    chk("t5 queued", queueCount, 3);
    flush = 1;
    cyc();
    flush = 0;
    chk("t5 flushed", queueCount, 0);
    sd.sdram_outputValid = 1; sd.sdram_readData = 16'h5555;
    cyc();
    sd.sdram_outputValid = 0;
    chk("t5 no rsp", rq.rsp_outputValid, 0);
    for (int i = 0; i < 5; i++) begin cyc(); chk("t5 idle", sd.sdram_inputValid, 0); end

    // 6: reset during ISSUE
    push(25'h500, 16'h0, 1);
    cyc();
    push(25'h501, 16'h0, 1);
    cyc();
    rq.req_inputValid = 0;
    chk("t6 in issue", sd.sdram_inputValid, 1);
    reset = 1;
    cyc();
    chk("t6 valid low", sd.sdram_inputValid, 0);
    chk("t6 count", queueCount, 0);
    chk("t6 errors", {overflowError, timeoutError}, 0);
    chk("t6 ready", rq.req_ready, 1);
    reset = 0;

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      rq.req_inputValid        = ($urandom_range(0, 99) < 50);
      rq.req_isWriting         = $urandom_range(0, 1);
      rq.req_inputAddress      = 25'($urandom);
      rq.req_writeData         = 16'($urandom);
      sd.sdram_isBusy          = ($urandom_range(0, 99) < 30);
      sd.sdram_recievedCommand = ($urandom_range(0, 99) < 40);
      sd.sdram_outputValid     = ($urandom_range(0, 99) < 20);
      sd.sdram_readData        = 16'($urandom);
      flush                    = ($urandom_range(0, 99) < 2);
      cyc();
    end
    rq.req_inputValid = 0; sd.sdram_recievedCommand = 0; sd.sdram_outputValid = 0; flush = 0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
